oet_sort_engine: RTL and testbench
==================================

Name: oet_sort_engine

Overview:
- Parametrised successor to the single-shot FSM sorter: sorts N keys of WIDTH bits using sequential odd-even transposition. Each cycle executes one compare-exchange phase across all disjoint adjacent pairs.
- Adds over the previous sorter:
  - ascending or descending mode, selected per job;
  - signed or unsigned compare;
  - stable ordering, with the original index of each output element reported;
  - early termination once the array is sorted;
  - valid/ready handshakes on both input and output.
- Sits between a sample-capture stage and downstream rank/median logic.

Parameters:
N, 6, number of keys per job (N >= 1).
WIDTH, 8, key width in bits.
SIGNED, 0, 1 = keys compared as two's-complement; 0 = unsigned.
IDXW, $clog2(N) (min 1), width of index tags.
PW, $clog2(N+1), width of the phase counter.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous active-low reset (0 = reset).
in_valid  in  1  job offered.
in_ready  out  1  engine can accept a job.
in_data  in  [N][WIDTH]  keys, element 0 first.
in_descend  in  1  0 = ascending, 1 = descending; sampled at accept.
out_valid  out  1  sorted result available.
out_ready  in  1  consumer accepts the result.
out_data  out  [N][WIDTH]  sorted keys.
out_index  out  [N][IDXW]  original position of each out_data element.
out_phases  out  PW  number of phases executed for this job.
busy  out  1  high in SORT or HOLD.

Behaviour:
- Reset (rst = 0, async): state = IDLE. All outputs are 0 except in_ready = 1. Key, index, phase and flag registers are cleared. Reset asserted mid-SORT or mid-HOLD aborts the job; no output is produced.
- States:
  - IDLE: in_ready = 1. On in_valid at an edge: load key[i] = in_data[i] and tag[i] = i, latch the direction, set phase = 0, go to SORT.
  - SORT: in_ready = 0 and in_valid is ignored. Each edge executes phase p:
    - p even: pairs (0,1), (2,3), …
    - p odd: pairs (1,2), (3,4), …
    - Keys move together with their tags.
    - Ascending swaps only if key[k] > key[k+1]. Descending swaps only if key[k] < key[k+1]. Strict compare guarantees stability.
    - Comparison is signed iff SIGNED = 1.
  - SORT exit: on the edge executing phase p, go to HOLD if p = N-1, or if p >= 1 and neither phase p-1 nor phase p swapped anything. out_phases = p+1 at that same edge.
  - HOLD: out_valid = 1. out_data, out_index and out_phases are stable. Go to IDLE on the edge where out_ready = 1; out_valid drops at that edge. in_ready stays 0 in HOLD, so the next job is accepted no earlier than the cycle after the hand-off.
- Latency: accept edge t0 → out_valid high after edge t0+P, where P = out_phases.
  - 2 <= P <= N for N >= 2; P = 1 for N = 1.
  - Presorted input gives P = 2.
  - Minimum job period: P+2 cycles.
- N = 1: one phase with no pairs, then HOLD; out_index[0] = 0. N = 2: the odd phase has no pairs.
- out_data and out_index show the live working registers. They are defined only while out_valid = 1.
- Nothing is combinational from inputs to outputs except none: all outputs are registered or decoded from state.

Test Plan:
- N=6, ascending, in_data [5,3,9,1,7,2] → out_data [1,2,3,5,7,9], out_index [3,5,1,0,4,2].
- Same data, in_descend = 1 → out_data [9,7,5,3,2,1], out_index [2,4,0,1,5,3].
- Stability, ascending, [4,4,1,4,0,1] → out_data [0,1,1,4,4,4], out_index [4,2,5,0,1,3].
- Early exit: [1,2,3,4,5,6] ascending → out_valid 2 cycles after accept, out_phases = 2. Reverse input [6,5,4,3,2,1] → out_phases = 6, out_data [1..6].
- SIGNED=1, ascending, [80,7F,FF,00,01,FE] hex → out_data [80,FE,FF,00,01,7F].
- Backpressure and reset:
  - Hold out_ready = 0 for 5 cycles: out_valid and out_data stay stable, and in_ready = 0 even with in_valid = 1. Raise out_ready: the next cycle shows in_ready = 1.
  - Drive rst = 0 during SORT phase 2: out_valid, busy and out_data go to 0 immediately and in_ready = 1. Then a fresh job sorts correctly.

Source files
------------

// File: rtl/oet_sort_engine.sv
// oet_sort_engine
//   Sorts N keys of WIDTH bits by sequential odd-even transposition. The
//   engine runs one compare-exchange phase per clock across all disjoint
//   adjacent pairs. It stops early once two consecutive phases make no swap.
//   Each key carries its original index, and equal keys never swap, so the
//   sort is stable.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active low (0 = reset)
//   in_valid    job offered; accepted on an edge while in_ready = 1
//   in_ready    engine idle and able to accept a job
//   in_data     N keys, element 0 first
//   in_descend  0 = ascending, 1 = descending; sampled at accept
//   out_valid   sorted result held and offered to the consumer
//   out_ready   consumer takes the result
//   out_data    sorted keys (meaningful only while out_valid = 1)
//   out_index   original position of each out_data element
//   out_phases  number of phases executed for the job
//   busy        high while sorting or holding a result
module oet_sort_engine #(
  parameter int N      = 6,
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0,
  parameter int IDXW   = (N > 1) ? $clog2(N) : 1,
  parameter int PW     = $clog2(N + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0][WIDTH-1:0]    in_data,
  input  logic                       in_descend,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0][WIDTH-1:0]    out_data,
  output logic [N-1:0][IDXW-1:0]     out_index,
  output logic [PW-1:0]              out_phases,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, SORT, HOLD} state_t;

  state_t                    state_reg, state_next;
  logic [N-1:0][WIDTH-1:0]   key_reg, key_next;
  logic [N-1:0][IDXW-1:0]    tag_reg, tag_next, tag_init;
  logic [PW-1:0]             phase_reg;      // phases executed so far
  logic                      desc_reg;
  logic                      prev_swap_reg;  // previous phase exchanged a pair
  logic [N-1:0]              swap;           // swap[k]: pair (k,k+1) exchanges now
  logic                      any_swap;
  logic                      last_phase;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_elem
      assign tag_init[gi] = IDXW'(gi);

      // Pair (gi, gi+1) takes part when its left index has the phase parity.
      // A strict compare leaves equal keys in place.
      if (gi < N - 1) begin : g_pair
        localparam logic PAR = 1'(gi % 2);
        logic gt, lt;
        if (SIGNED) begin : g_signed
          assign gt = $signed(key_reg[gi]) > $signed(key_reg[gi+1]);
          assign lt = $signed(key_reg[gi]) < $signed(key_reg[gi+1]);
        end else begin : g_unsigned
          assign gt = key_reg[gi] > key_reg[gi+1];
          assign lt = key_reg[gi] < key_reg[gi+1];
        end
        assign swap[gi] = (phase_reg[0] == PAR) && (desc_reg ? lt : gt);
      end else begin : g_no_pair
        assign swap[gi] = 1'b0;
      end

      // Active pairs are disjoint, so each slot takes its value from at most
      // one neighbour. Tags follow their keys.
      if (gi > 0 && gi < N - 1) begin : g_mid
        assign key_next[gi] = swap[gi] ? key_reg[gi+1] : (swap[gi-1] ? key_reg[gi-1] : key_reg[gi]);
        assign tag_next[gi] = swap[gi] ? tag_reg[gi+1] : (swap[gi-1] ? tag_reg[gi-1] : tag_reg[gi]);
      end else if (gi < N - 1) begin : g_first
        assign key_next[gi] = swap[gi] ? key_reg[gi+1] : key_reg[gi];
        assign tag_next[gi] = swap[gi] ? tag_reg[gi+1] : tag_reg[gi];
      end else if (gi > 0) begin : g_last
        assign key_next[gi] = swap[gi-1] ? key_reg[gi-1] : key_reg[gi];
        assign tag_next[gi] = swap[gi-1] ? tag_reg[gi-1] : tag_reg[gi];
      end else begin : g_single
        assign key_next[gi] = key_reg[gi];
        assign tag_next[gi] = tag_reg[gi];
      end
    end
  endgenerate

  assign any_swap = |swap;

  // Finish after phase N-1. Finish earlier once two consecutive phases,
  // one of each parity, have left every adjacent pair in order.
  assign last_phase = (phase_reg == PW'(N - 1)) ||
                      ((phase_reg != '0) && !prev_swap_reg && !any_swap);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (last_phase) state_next = HOLD;
      end
      HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Working registers. After the final phase, phase_reg holds the number of
  // phases executed, and it stays unchanged through HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_reg       <= '0;
      tag_reg       <= '0;
      phase_reg     <= '0;
      desc_reg      <= 1'b0;
      prev_swap_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            key_reg       <= in_data;
            tag_reg       <= tag_init;
            desc_reg      <= in_descend;
            phase_reg     <= '0;
            prev_swap_reg <= 1'b0;
          end
        end
        SORT: begin
          key_reg       <= key_next;
          tag_reg       <= tag_next;
          prev_swap_reg <= any_swap;
          phase_reg     <= phase_reg + PW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_data   = key_reg;
  assign out_index  = tag_reg;
  assign out_phases = phase_reg;

endmodule

// File: tb/tb_oet_sort_engine.sv
module tb_oet_sort_engine;
  localparam int N  = 6;
  localparam int W  = 8;
  localparam int IW = 3;
  localparam int PB = 3;

  typedef logic [N-1:0][W-1:0]  vec_t;
  typedef logic [N-1:0][IW-1:0] ivec_t;

  typedef struct {
    string name;
    vec_t  d;
    bit    desc;
    bit    sgn;
    vec_t  ed;
    ivec_t ei;
    int    ep;   // 0: take the phase count from the reference model
  } rec_t;

  logic         clk = 1'b0;
  logic         rst;
  vec_t         in_data;
  logic         in_descend;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  vec_t         out_data;
  ivec_t        out_index;
  logic [PB-1:0] out_phases;
  logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  vec_t         s_out_data;
  ivec_t        s_out_index;
  logic [PB-1:0] s_out_phases;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  oet_sort_engine #(.N(N), .WIDTH(W), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_descend(in_descend), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_phases(out_phases), .busy(busy));

  oet_sort_engine #(.N(N), .WIDTH(W), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_descend(in_descend), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_data(s_out_data), .out_index(s_out_index),
    .out_phases(s_out_phases), .busy(s_busy));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input int a0, a1, a2, a3, a4, a5);
    vec_t v;
    v[0] = W'(a0); v[1] = W'(a1); v[2] = W'(a2);
    v[3] = W'(a3); v[4] = W'(a4); v[5] = W'(a5);
    return v;
  endfunction

  function automatic ivec_t mki(input int a0, a1, a2, a3, a4, a5);
    ivec_t v;
    v[0] = IW'(a0); v[1] = IW'(a1); v[2] = IW'(a2);
    v[3] = IW'(a3); v[4] = IW'(a4); v[5] = IW'(a5);
    return v;
  endfunction

  function automatic int keyval(input logic [W-1:0] x, input bit sgn);
    if (sgn) return int'($signed(x));
    return int'(x);
  endfunction

  // Reference. Each element's output rank is the number of elements that
  // must precede it: strictly smaller (or larger when descending), or equal
  // with a lower original index. The phase count comes from replaying
  // odd-even transposition on plain ints with the early-exit rule.
  function automatic void model(input vec_t d, input bit desc, input bit sgn,
                                output vec_t od, output ivec_t oi, output int ph);
    int a[N];
    int rank, t;
    bit sw, prev;
    od = '0; oi = '0; ph = 0; prev = 1'b0;
    for (int i = 0; i < N; i++) begin
      rank = 0;
      for (int j = 0; j < N; j++) begin
        if (desc ? (keyval(d[j], sgn) > keyval(d[i], sgn)) : (keyval(d[j], sgn) < keyval(d[i], sgn)))
          rank++;
        else if (keyval(d[j], sgn) == keyval(d[i], sgn) && j < i)
          rank++;
      end
      od[rank] = d[i];
      oi[rank] = IW'(i);
    end
    for (int i = 0; i < N; i++) a[i] = keyval(d[i], sgn);
    for (int p = 0; p < N; p++) begin
      sw = 1'b0;
      for (int k = p % 2; k + 1 < N; k += 2) begin
        if (desc ? (a[k] < a[k+1]) : (a[k] > a[k+1])) begin
          t = a[k]; a[k] = a[k+1]; a[k+1] = t; sw = 1'b1;
        end
      end
      if (p == N - 1 || (p >= 1 && !sw && !prev)) begin
        ph = p + 1;
        break;
      end
      prev = sw;
    end
  endfunction

  // Call at posedge+1 with the selected engine idle.
  task automatic run_job(input bit use_s, input vec_t d, input bit desc, input int hold,
                         output vec_t od, output ivec_t oi, output int ph, output int lat);
    in_data = d;
    in_descend = desc;
    if (use_s) s_in_valid = 1'b1;
    else       in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    s_in_valid = 1'b0;
    lat = 0;
    while (!(use_s ? s_out_valid : out_valid) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    od = use_s ? s_out_data : out_data;
    oi = use_s ? s_out_index : out_index;
    ph = int'(use_s ? s_out_phases : out_phases);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    s_out_ready = 1'b0;
  endtask

  task automatic do_job(input string name, input bit sgn, input vec_t d, input bit desc,
                        input vec_t ed, input ivec_t ei, input int ep, input int hold);
    vec_t od;
    ivec_t oi;
    int ph, lat;
    run_job(sgn, d, desc, hold, od, oi, ph, lat);
    check({name, " data"}, 64'(od), 64'(ed));
    check({name, " index"}, 64'(oi), 64'(ei));
    check({name, " phases"}, 64'(ph), 64'(ep));
    check({name, " latency"}, 64'(lat), 64'(ep));
    $display("%s: in=%h desc=%0d signed=%0d out=%h idx=%h phases=%0d lat=%0d",
             name, d, desc, sgn, od, oi, ph, lat);
  endtask

  rec_t  tbl[7];
  vec_t  md, rd;
  ivec_t mi;
  int    mp, cnt, ep;
  bit    rdesc, rsgn;

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; s_in_valid = 1'b0;
    out_ready = 1'b0; s_out_ready = 1'b0;
    in_data = '0; in_descend = 1'b0;

    tbl[0] = '{"asc",     mk(5,3,9,1,7,2), 1'b0, 1'b0, mk(1,2,3,5,7,9), mki(3,5,1,0,4,2), 0};
    tbl[1] = '{"desc",    mk(5,3,9,1,7,2), 1'b1, 1'b0, mk(9,7,5,3,2,1), mki(2,4,0,1,5,3), 0};
    tbl[2] = '{"stable",  mk(4,4,1,4,0,1), 1'b0, 1'b0, mk(0,1,1,4,4,4), mki(4,2,5,0,1,3), 0};
    tbl[3] = '{"presort", mk(1,2,3,4,5,6), 1'b0, 1'b0, mk(1,2,3,4,5,6), mki(0,1,2,3,4,5), 2};
    tbl[4] = '{"reverse", mk(6,5,4,3,2,1), 1'b0, 1'b0, mk(1,2,3,4,5,6), mki(5,4,3,2,1,0), 6};
    tbl[5] = '{"signed",  mk('h80,'h7F,'hFF,'h00,'h01,'hFE), 1'b0, 1'b1,
               mk('h80,'hFE,'hFF,'h00,'h01,'h7F), mki(0,5,2,3,4,1), 0};
    tbl[6] = '{"desc_stable", mk(2,2,7,2,7,0), 1'b1, 1'b0, mk(7,7,2,2,2,0), mki(2,4,0,1,3,5), 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst out_data", 64'(out_data), 64'd0);
    check("rst out_index", 64'(out_index), 64'd0);
    check("rst out_phases", 64'(out_phases), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed table
    foreach (tbl[i]) begin
      model(tbl[i].d, tbl[i].desc, tbl[i].sgn, md, mi, mp);
      ep = (tbl[i].ep != 0) ? tbl[i].ep : mp;
      do_job(tbl[i].name, tbl[i].sgn, tbl[i].d, tbl[i].desc, tbl[i].ed, tbl[i].ei, ep, i % 3);
    end

    // Backpressure: hold the result 5 cycles with in_valid asserted throughout
    rd = mk(5,3,9,1,7,2);
    model(rd, 1'b0, 1'b0, md, mi, mp);
    in_data = rd; in_descend = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp sort in_ready", 64'(in_ready), 64'd0);
    check("bp sort busy", 64'(busy), 64'd1);
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("bp latency", 64'(cnt), 64'(mp));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold%0d out_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("bp hold%0d out_data", c), 64'(out_data), 64'(md));
      check($sformatf("bp hold%0d in_ready", c), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release in_ready", 64'(in_ready), 64'd1);
    check("bp release out_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    $display("backpressure: out=%h held 5 cycles", md);
    @(posedge clk); #1;

    // Reset while phase 2 is pending
    in_data = mk(6,5,4,3,2,1); in_descend = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort out_data", 64'(out_data), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd1);
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    check("after abort out_valid", 64'(out_valid), 64'd0);
    $display("reset abort: engine idle");
    rd = mk(9,0,4,4,200,1);
    model(rd, 1'b1, 1'b0, md, mi, mp);
    do_job("post_reset", 1'b0, rd, 1'b1, md, mi, mp, 1);

    // Randomized jobs against the reference model
    for (int j = 0; j < 120; j++) begin
      for (int e = 0; e < N; e++) rd[e] = W'($urandom_range(0, (j % 2 == 1) ? 255 : 3));
      rdesc = 1'($urandom_range(0, 1));
      rsgn  = (j % 4 == 3);
      model(rd, rdesc, rsgn, md, mi, mp);
      do_job($sformatf("rand%0d", j), rsgn, rd, rdesc, md, mi, mp, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
